// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 16-bit CPU control path.
//   - sequencer state encoding
//   - 8-bit ALU opcodes (shared with the ALU)
//   - 4-bit major opcodes (IR[15:12]) and shift extensions (IR[7:4])
//   - status flag bit positions within {N,Z,F,L,C}
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_FETCH     = 2'd0,
    ST_DECODE    = 2'd1,
    ST_EXECUTE   = 2'd2,
    ST_WRITEBACK = 2'd3
  } state_e;

  localparam logic [7:0] OP_WAIT = 8'h00;
  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_ADDU = 8'h06;
  localparam logic [7:0] OP_ADDC = 8'h07;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_SUBC = 8'h0A;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_MUL  = 8'h0E;
  localparam logic [7:0] OP_LSH  = 8'h84;
  localparam logic [7:0] OP_ASHU = 8'h86;

  // Major opcodes. Register-form extension codes reuse the same values
  // (e.g. ADD is 0101 both as a major and as a register extension).
  localparam logic [3:0] MAJ_REG   = 4'h0;
  localparam logic [3:0] MAJ_AND   = 4'h1;
  localparam logic [3:0] MAJ_OR    = 4'h2;
  localparam logic [3:0] MAJ_XOR   = 4'h3;
  localparam logic [3:0] MAJ_ADD   = 4'h5;
  localparam logic [3:0] MAJ_ADDU  = 4'h6;
  localparam logic [3:0] MAJ_ADDC  = 4'h7;
  localparam logic [3:0] MAJ_SHIFT = 4'h8;
  localparam logic [3:0] MAJ_SUB   = 4'h9;
  localparam logic [3:0] MAJ_SUBC  = 4'hA;
  localparam logic [3:0] MAJ_CMP   = 4'hB;
  localparam logic [3:0] MAJ_MUL   = 4'hE;

  localparam logic [3:0] EXT_LSH  = 4'h4;
  localparam logic [3:0] EXT_ASHU = 4'h6;

  localparam int FLAG_C = 0;
  localparam int FLAG_L = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 4;

  // Arithmetic ops (register or immediate form) update the status register.
  function automatic logic is_flag_op(input logic [7:0] op);
    case (op)
      OP_ADD, OP_ADDU, OP_ADDC, OP_MUL,
      OP_SUB, OP_SUBC, OP_CMP: is_flag_op = 1'b1;
      default:                 is_flag_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_decode.sv
// instr_decode: combinational decode of one 16-bit instruction word.
//   ir           in   instruction register
//   rd, rs       out  IR[11:8] (Rdest / write-back) and IR[3:0] (Rsrc)
//   alu_opcode   out  8-bit ALU opcode (8'h00 for illegal encodings)
//   imm_sel      out  1 = ALU r2 uses imm_out
//   imm_out      out  sign- or zero-extended IR[7:0] for immediate forms
//   writes_rf    out  instruction writes Rdest
//   writes_flags out instruction latches the ALU flags
//   illegal_enc  out  encoding is not decodable
module instr_decode
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output logic [3:0]  rd,
  output logic [3:0]  rs,
  output logic [7:0]  alu_opcode,
  output logic        imm_sel,
  output logic [15:0] imm_out,
  output logic        writes_rf,
  output logic        writes_flags,
  output logic        illegal_enc
);

  logic [3:0] major, ext;
  logic [7:0] imm8;

  assign major = ir[15:12];
  assign ext   = ir[7:4];
  assign imm8  = ir[7:0];
  assign rd    = ir[11:8];
  assign rs    = ir[3:0];

  always_comb begin
    alu_opcode  = OP_WAIT;
    imm_sel     = 1'b0;
    imm_out     = 16'h0000;
    illegal_enc = 1'b0;
    case (major)
      MAJ_REG: begin
        case (ext)
          MAJ_REG, MAJ_AND, MAJ_OR, MAJ_XOR, MAJ_ADD, MAJ_ADDU,
          MAJ_ADDC, MAJ_MUL, MAJ_SUB, MAJ_SUBC, MAJ_CMP:
                   alu_opcode  = {4'h0, ext};
          default: illegal_enc = 1'b1;
        endcase
      end
      MAJ_SHIFT: begin
        if (ext == EXT_LSH || ext == EXT_ASHU) alu_opcode  = {MAJ_SHIFT, ext};
        else                                   illegal_enc = 1'b1;
      end
      // Logic ops and ADDU take an unsigned immediate.
      MAJ_AND, MAJ_OR, MAJ_XOR, MAJ_ADDU: begin
        alu_opcode = {4'h0, major};
        imm_sel    = 1'b1;
        imm_out    = {8'h00, imm8};
      end
      MAJ_ADD, MAJ_ADDC, MAJ_MUL, MAJ_SUB, MAJ_SUBC, MAJ_CMP: begin
        alu_opcode = {4'h0, major};
        imm_sel    = 1'b1;
        imm_out    = {{8{imm8[7]}}, imm8};
      end
      default: illegal_enc = 1'b1;
    endcase
  end

  // WAIT and CMP produce no register result; illegal encodings decode to WAIT.
  assign writes_rf    = !illegal_enc && (alu_opcode != OP_WAIT) && (alu_opcode != OP_CMP);
  assign writes_flags = !illegal_enc && is_flag_op(alu_opcode);

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle fetch/decode/execute/write-back controller for
// the 16-bit ALU. One instruction in flight, 4 cycles each when memory
// answers in the request cycle.
//   clk, reset            clock, async active-high reset
//   instr_data/valid/req  instruction fetch handshake, pc_out = fetch address
//   rf_raddr_a/b          register-file read addresses (Rdest, Rsrc)
//   imm_sel, imm_out      immediate operand select and value
//   alu_opcode, alu_flags ALU control and returned {N,Z,F,L,C}
//   rf_waddr, rf_we       register write-back
//   flags_out             latched status register
//   illegal               one-cycle pulse on an undecodable instruction
module alu_sequencer
  import cpu_pkg::*;
#(
  parameter logic [15:0] PC_RESET     = 16'h0000,
  parameter bit          ILLEGAL_TRAP = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr_data,
  input  logic        instr_valid,
  output logic        instr_req,
  output logic [15:0] pc_out,
  output logic [3:0]  rf_raddr_a,
  output logic [3:0]  rf_raddr_b,
  output logic        imm_sel,
  output logic [15:0] imm_out,
  output logic [7:0]  alu_opcode,
  input  logic [4:0]  alu_flags,
  output logic [3:0]  rf_waddr,
  output logic        rf_we,
  output logic [4:0]  flags_out,
  output logic        illegal
);

  state_e      state;
  logic [15:0] ir;
  logic [3:0]  rd;
  logic        writes_rf, writes_flags, illegal_enc;

  // Decode is driven straight from IR, which only changes on the fetch edge,
  // so decode outputs hold from DECODE through WRITEBACK. IR resets to 0
  // (WAIT), which decodes to all-zero outputs.
  instr_decode u_dec (
    .ir           (ir),
    .rd           (rd),
    .rs           (rf_raddr_b),
    .alu_opcode   (alu_opcode),
    .imm_sel      (imm_sel),
    .imm_out      (imm_out),
    .writes_rf    (writes_rf),
    .writes_flags (writes_flags),
    .illegal_enc  (illegal_enc)
  );

  assign rf_raddr_a = rd;
  assign rf_waddr   = rd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_FETCH;
      pc_out    <= PC_RESET;
      ir        <= 16'h0000;
      flags_out <= 5'b00000;
    end else begin
      case (state)
        ST_FETCH: begin
          if (instr_valid) begin
            ir    <= instr_data;
            state <= ST_DECODE;
          end
        end
        ST_DECODE:  state <= ST_EXECUTE;
        ST_EXECUTE: state <= ST_WRITEBACK;
        ST_WRITEBACK: begin
          if (writes_flags) flags_out <= alu_flags;
          pc_out <= pc_out + 16'd1;
          state  <= ST_FETCH;
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

  // Request is masked while reset is held so it first rises as reset releases.
  assign instr_req = (state == ST_FETCH) && !reset;
  assign rf_we     = (state == ST_WRITEBACK) && writes_rf;
  assign illegal   = (state == ST_WRITEBACK) && illegal_enc && ILLEGAL_TRAP;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a cycle model checked every negedge plus
// literal per-instruction expectations from a hand-built vector table.
module tb_alu_sequencer;

  localparam logic [15:0] PCR = 16'hFFFC;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] instr_data = 16'h0000;
  logic        instr_valid = 1'b0;
  logic [4:0]  alu_flags = 5'b00000;
  logic        instr_req, imm_sel, rf_we, illegal;
  logic [15:0] pc_out, imm_out;
  logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [7:0]  alu_opcode;
  logic [4:0]  flags_out;

  always #5 clk = ~clk;

  alu_sequencer #(.PC_RESET(PCR), .ILLEGAL_TRAP(1'b1)) dut (
    .clk(clk), .reset(reset), .instr_data(instr_data), .instr_valid(instr_valid),
    .instr_req(instr_req), .pc_out(pc_out), .rf_raddr_a(rf_raddr_a),
    .rf_raddr_b(rf_raddr_b), .imm_sel(imm_sel), .imm_out(imm_out),
    .alu_opcode(alu_opcode), .alu_flags(alu_flags), .rf_waddr(rf_waddr),
    .rf_we(rf_we), .flags_out(flags_out), .illegal(illegal)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference decode (instruction-set table) ----------------
  typedef struct packed {
    logic [7:0]  op;
    logic        sel;
    logic [15:0] imm;
    logic        wr;
    logic        fl;
    logic        ill;
  } exp_t;

  function automatic exp_t ref_dec(input logic [15:0] d);
    exp_t e;
    logic [3:0] maj, ext;
    maj = d[15:12];
    ext = d[7:4];
    e = '0;
    if (maj == 4'h0 && (ext inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hE}))
      e.op = {4'h0, ext};
    else if (maj == 4'h8 && (ext == 4'h4 || ext == 4'h6))
      e.op = {4'h8, ext};
    else if (maj inside {4'h5, 4'h6, 4'h7, 4'hE, 4'h9, 4'hA, 4'hB, 4'h1, 4'h2, 4'h3}) begin
      e.op  = {4'h0, maj};
      e.sel = 1'b1;
      if (maj inside {4'h5, 4'h7, 4'hE, 4'h9, 4'hA, 4'hB}) e.imm = 16'($signed(d[7:0]));
      else                                                e.imm = {8'h00, d[7:0]};
    end else
      e.ill = 1'b1;
    e.wr = !e.ill && !(e.op inside {8'h00, 8'h0B});
    e.fl = !e.ill && (e.op inside {8'h05, 8'h06, 8'h07, 8'h0E, 8'h09, 8'h0A, 8'h0B});
    return e;
  endfunction

  // ---------------- cycle model: cycles elapsed since acceptance ----------------
  int          m_cnt = 0;
  logic [15:0] m_pc = PCR;
  logic [15:0] m_ir = 16'h0000;
  logic [4:0]  m_flags = 5'b00000;
  exp_t        m_e;
  assign m_e = ref_dec(m_ir);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt <= 0; m_pc <= PCR; m_ir <= 16'h0000; m_flags <= 5'b00000;
    end else if (m_cnt == 0) begin
      if (instr_valid) begin m_ir <= instr_data; m_cnt <= 1; end
    end else if (m_cnt < 3) begin
      m_cnt <= m_cnt + 1;
    end else begin
      if (m_e.fl) m_flags <= alu_flags;
      m_pc  <= m_pc + 16'd1;
      m_cnt <= 0;
    end
  end

  always @(negedge clk) begin
    chk("instr_req", instr_req, (m_cnt == 0 && !reset));
    chk("pc_out", pc_out, m_pc);
    chk("rf_raddr_a", rf_raddr_a, m_ir[11:8]);
    chk("rf_raddr_b", rf_raddr_b, m_ir[3:0]);
    chk("rf_waddr", rf_waddr, m_ir[11:8]);
    chk("alu_opcode", alu_opcode, m_e.op);
    chk("imm_sel", imm_sel, m_e.sel);
    if (m_e.sel) chk("imm_out", imm_out, m_e.imm);
    chk("rf_we", rf_we, (m_cnt == 3 && m_e.wr));
    chk("illegal", illegal, (m_cnt == 3 && m_e.ill));
    chk("flags_out", flags_out, m_flags);
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [15:0] d;
    logic [4:0]  f;
    int          gap;
    bit          hold;
    logic [7:0]  op;
    bit          sel;
    logic [15:0] imm;
    bit          we;
    bit          ill;
    logic [4:0]  fl_after;
    logic [15:0] pc_after;
  } vec_t;

  localparam int NV = 15;
  vec_t vt [NV] = '{
    '{16'h0351, 5'b01000, 0, 1'b0, 8'h05, 1'b0, 16'h0000, 1'b1, 1'b0, 5'b01000, 16'hFFFD}, // ADD R3,R1
    '{16'h52FF, 5'b00001, 0, 1'b0, 8'h05, 1'b1, 16'hFFFF, 1'b1, 1'b0, 5'b00001, 16'hFFFE}, // ADDI R2,-1
    '{16'h12FF, 5'b11111, 0, 1'b1, 8'h01, 1'b1, 16'h00FF, 1'b1, 1'b0, 5'b00001, 16'hFFFF}, // ANDI
    '{16'hF000, 5'b11111, 0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 5'b00001, 16'h0000}, // illegal, wrap
    '{16'h04B2, 5'b10100, 5, 1'b0, 8'h0B, 1'b0, 16'h0000, 1'b0, 1'b0, 5'b10100, 16'h0001}, // CMP after stall
    '{16'h8146, 5'b11111, 0, 1'b0, 8'h84, 1'b0, 16'h0000, 1'b1, 1'b0, 5'b10100, 16'h0002}, // LSH
    '{16'h8156, 5'b11111, 0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 5'b10100, 16'h0003}, // bad shift
    '{16'h0000, 5'b11111, 0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 5'b10100, 16'h0004}, // WAIT
    '{16'h0392, 5'b00010, 0, 1'b0, 8'h09, 1'b0, 16'h0000, 1'b1, 1'b0, 5'b00010, 16'h0005}, // SUB
    '{16'hE305, 5'b00100, 0, 1'b0, 8'h0E, 1'b1, 16'h0005, 1'b1, 1'b0, 5'b00100, 16'h0006}, // MULI
    '{16'h2380, 5'b11111, 0, 1'b0, 8'h02, 1'b1, 16'h0080, 1'b1, 1'b0, 5'b00100, 16'h0007}, // ORI
    '{16'h9380, 5'b00001, 0, 1'b0, 8'h09, 1'b1, 16'hFF80, 1'b1, 1'b0, 5'b00001, 16'h0008}, // SUBI
    '{16'h04C1, 5'b11111, 0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 5'b00001, 16'h0009}, // bad reg ext
    '{16'h8562, 5'b11111, 0, 1'b0, 8'h86, 1'b0, 16'h0000, 1'b1, 1'b0, 5'b00001, 16'h000A}, // ASHU
    '{16'h0763, 5'b10000, 0, 1'b0, 8'h06, 1'b0, 16'h0000, 1'b1, 1'b0, 5'b10000, 16'h000B}  // ADDU
  };

  logic        dec_req, wb_we, wb_ill, wb_sel, post_req;
  logic [7:0]  wb_op;
  logic [15:0] wb_imm, post_pc;
  logic [3:0]  wb_waddr;
  logic [4:0]  post_flags;

  task automatic wait_req();
    int n = 0;
    while (!instr_req && n < 20) begin @(negedge clk); n++; end
    if (!instr_req) chk("fetch_wait_timeout", 32'd0, 32'd1);
  endtask

  // Issue one instruction; hold keeps instr_valid high (with junk data)
  // through DECODE..WRITEBACK to show it is ignored there.
  task automatic issue(input logic [15:0] d, input logic [4:0] f, input int gap, input bit hold);
    wait_req();
    repeat (gap) @(negedge clk);
    #1 instr_valid = 1'b1; instr_data = d; alu_flags = f;
    @(posedge clk); #1;
    instr_valid = hold; instr_data = 16'h0A5A;
    @(negedge clk); dec_req = instr_req;
    @(negedge clk);
    @(negedge clk);
    wb_we = rf_we; wb_ill = illegal; wb_op = alu_opcode; wb_sel = imm_sel;
    wb_imm = imm_out; wb_waddr = rf_waddr;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    post_pc = pc_out; post_flags = flags_out; post_req = instr_req;
  endtask

  initial begin
    #1 reset = 1'b1;
    #2;
    chk("reset_pc", pc_out, PCR);
    chk("reset_req", instr_req, 1'b0);
    chk("reset_opcode", alu_opcode, 8'h00);
    @(negedge clk); @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("req_after_reset", instr_req, 1'b1);

    for (int i = 0; i < NV; i++) begin
      issue(vt[i].d, vt[i].f, vt[i].gap, vt[i].hold);
      chk($sformatf("v%0d_decode_req", i), dec_req, 1'b0);
      chk($sformatf("v%0d_we", i), wb_we, vt[i].we);
      chk($sformatf("v%0d_illegal", i), wb_ill, vt[i].ill);
      chk($sformatf("v%0d_opcode", i), wb_op, vt[i].op);
      chk($sformatf("v%0d_imm_sel", i), wb_sel, vt[i].sel);
      if (vt[i].sel) chk($sformatf("v%0d_imm", i), wb_imm, vt[i].imm);
      chk($sformatf("v%0d_waddr", i), wb_waddr, vt[i].d[11:8]);
      chk($sformatf("v%0d_pc", i), post_pc, vt[i].pc_after);
      chk($sformatf("v%0d_flags", i), post_flags, vt[i].fl_after);
      chk($sformatf("v%0d_next_req", i), post_req, 1'b1);
    end

    // Reset during EXECUTE of an ADD: no write, everything back to reset.
    wait_req();
    #1 instr_valid = 1'b1; instr_data = 16'h0351; alu_flags = 5'b01010;
    @(posedge clk); #1 instr_valid = 1'b0;
    @(posedge clk); #2 reset = 1'b1;
    #1;
    chk("rst_exec_we", rf_we, 1'b0);
    chk("rst_exec_pc", pc_out, PCR);
    chk("rst_exec_flags", flags_out, 5'b00000);
    chk("rst_exec_opcode", alu_opcode, 8'h00);
    chk("rst_exec_req", instr_req, 1'b0);
    @(negedge clk); @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("rst_exec_resume_req", instr_req, 1'b1);

    issue(16'h7A80, 5'b00011, 0, 1'b0); // ADDCI R10,-128
    chk("post_rst_opcode", wb_op, 8'h07);
    chk("post_rst_imm", wb_imm, 16'hFF80);
    chk("post_rst_we", wb_we, 1'b1);
    chk("post_rst_pc", post_pc, 16'hFFFD);
    chk("post_rst_flags", post_flags, 5'b00011);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Control-side partner of the 16-bit ALU: fetches each instruction word and decodes it into the ALU's 8-bit opcode, register-file addresses and immediate.
- Sequences the register write-back and latches the processor status flags.
- Sits between instruction memory, the register file and the ALU in the 16-bit FPGA CPU.
- Multi-cycle (non-pipelined) FSM, one instruction in flight.

Parameters:
- PC_RESET, 16'h0000, pc_out value after reset.
- ILLEGAL_TRAP, 1, 1 = pulse illegal and skip the instruction; 0 = treat it as a no-op with no pulse.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- instr_data  input  16  instruction word from memory.
- instr_valid  input  1  instr_data valid; sampled only while instr_req=1.
- instr_req  output  1  fetch request, held until instr_valid.
- pc_out  output  16  address of the instruction being fetched.
- rf_raddr_a  output  4  Rdest read address (ALU r1), IR[11:8].
- rf_raddr_b  output  4  Rsrc read address (ALU r2 when register form), IR[3:0].
- imm_sel  output  1  1 = ALU r2 takes imm_out instead of the register.
- imm_out  output  16  extended immediate.
- alu_opcode  output  8  opcode to the ALU.
- alu_flags  input  5  flags produced by the ALU, {N,Z,F,L,C}.
- rf_waddr  output  4  write-back address, = IR[11:8].
- rf_we  output  1  register write strobe.
- flags_out  output  5  latched status register {N,Z,F,L,C}.
- illegal  output  1  one-cycle pulse on an undecodable instruction.

Behaviour:
- Reset, asynchronous: state=FETCH; pc_out=PC_RESET; IR, alu_opcode, imm_out, flags_out, rf_raddr_a/b and rf_waddr =0; instr_req, rf_we, imm_sel, illegal =0. The first instr_req=1 appears in the first cycle after reset deasserts.
- A reset mid-instruction aborts it: no write, flags unchanged from their reset value.
- States: FETCH -> DECODE -> EXECUTE -> WRITEBACK -> FETCH.
- FETCH:
  - instr_req=1, pc_out stable.
  - On an edge with instr_valid=1: IR<=instr_data, go to DECODE.
  - Otherwise stay; there is no timeout.
- DECODE: drive rf_raddr_a/b, alu_opcode, imm_sel and imm_out from IR. Outputs stay stable through EXECUTE and WRITEBACK.
- EXECUTE: one cycle for ALU and register-file settling. The ALU is combinational.
- WRITEBACK:
  - rf_we=1 for exactly this cycle, except CMP/CMPI, illegal instructions and no-ops.
  - Flag-updating ops latch flags_out<=alu_flags on this edge.
  - pc_out<=pc_out+1, wrapping from 16'hFFFF to 16'h0000.
- Latency: 4 cycles per instruction when instr_valid returns in the request cycle. instr_valid outside FETCH is ignored.
- Register form: IR[15:12]=0000 gives alu_opcode={4'b0000, IR[7:4]}, imm_sel=0. Legal extensions: 0101 ADD, 0110 ADDU, 0111 ADDC, 1110 MUL, 1001 SUB, 1010 SUBC, 1011 CMP, 0001 AND, 0010 OR, 0011 XOR, 0000 WAIT.
- Shift form: IR[15:12]=1000 with IR[7:4]=0100 (LSH) or 0110 (ASHU) gives alu_opcode={1000, IR[7:4]}, imm_sel=0.
- Immediate form: IR[15:12] in {0101,0110,0111,1110,1001,1010,1011,0001,0010,0011} gives alu_opcode={4'b0000, IR[15:12]}, imm_sel=1.
  - imm_out = sign-extended IR[7:0] for 0101, 0111, 1110, 1001, 1010, 1011.
  - imm_out = zero-extended IR[7:0] for 0110, 0001, 0010, 0011.
- Flag-updating ops: ADD, ADDU, ADDC, MUL, SUB, SUBC, CMP and their immediate forms. Logic, shift and WAIT ops leave flags_out unchanged.
- WAIT (16'h0000): no write, no flag update. The PC advances and execution continues.
- Illegal encoding (anything else):
  - illegal=1 during the WRITEBACK cycle when ILLEGAL_TRAP=1.
  - rf_we=0, flags unchanged, PC advances.
  - alu_opcode is driven 8'h00 for that instruction.
- rf_we and illegal are never asserted in the same cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - the state enum;
  - the 8-bit ALU opcode constants (OP_ADD=8'h05, etc.), shared with the ALU;
  - the 4-bit major-opcode constants;
  - flag bit indices FLAG_C=0, FLAG_L=1, FLAG_F=2, FLAG_Z=3, FLAG_N=4.
- Sub-module instr_decode: combinational. IR in; alu_opcode, imm_sel, imm_out, writes_rf, writes_flags and illegal_enc out.
- alu_sequencer keeps the FSM, the PC, the IR and the flag register.

Test Plan:
- Reset then instr_valid=1 immediately with instr_data=16'h0351 (ADD R3,R1) -> in WRITEBACK: rf_we=1, rf_waddr=3, alu_opcode=8'h05, imm_sel=0; pc_out 0->1; 4 cycles per instruction.
- instr_data=16'h52FF (ADDI R2,-1), alu_flags=5'b00001 -> imm_out=16'hFFFF, imm_sel=1, alu_opcode=8'h05, flags_out=5'b00001 after WRITEBACK.
- instr_data=16'h12FF (ANDI) -> imm_out=16'h00FF, rf_we pulse, flags_out unchanged; 16'h04B2 (CMP) -> rf_we stays 0, flags latched.
- instr_valid held low for 5 cycles during FETCH -> instr_req stays 1, pc_out constant, no rf_we; assert instr_valid -> proceeds normally.
- instr_data=16'hF000 (illegal) -> illegal pulses 1 cycle, rf_we=0, flags unchanged, pc_out increments; with pc_out=16'hFFFF the next pc_out=16'h0000.
- Assert reset during EXECUTE of an ADD -> all outputs 0 asynchronously, no rf_we, pc_out=PC_RESET, FETCH resumes after deassertion.
